// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory store responder
// Purpose : FSM state encoding, store-trace record layout and default
//           status-register constants shared by the responder and its FIFO.
// Contents: dmem_state_t, store_rec_t, STATUS_ADDR_DEF, PASS_VALUE_DEF.
package dmem_pkg;

   typedef enum logic [1:0] {
      RUN,
      PASS,
      FAIL
   } dmem_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } store_rec_t;

   localparam logic [31:0] STATUS_ADDR_DEF = 32'd100;
   localparam logic [31:0] PASS_VALUE_DEF  = 32'd25;

endpackage

// File: rtl/store_trace_fifo.sv
// rtl/store_trace_fifo.sv - synchronous FIFO of store records with sticky overflow
// Purpose : Holds recent accepted stores for a debug consumer. No fall-through:
//           a pushed record is visible at the head from the next cycle.
// Ports   : clk, rst (async, active-high)
//           push, push_rec      - write request and record
//           pop                 - remove head (ignored while empty)
//           head                - current head record (0 when never written)
//           empty               - no records held
//           overflow            - sticky, a push was dropped while full
module store_trace_fifo
   import dmem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  store_rec_t push_rec,
   input  logic       pop,
   output store_rec_t head,
   output logic       empty,
   output logic       overflow
);

   localparam int AW = $clog2(DEPTH);

   store_rec_t       mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             do_pop;
   logic             do_push;

   // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A same-cycle pop frees the slot the push lands in, so a full FIFO still accepts.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_rec;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !do_push) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_store_responder.sv
// rtl/dmem_store_responder.sv - data-memory responder with status register, store counter and trace
// Purpose : Word RAM (combinational read, synchronous write) behind the core's
//           store port, plus a pass/fail status register, a saturating count of
//           accepted stores and a trace FIFO of those stores.
// Ports   : clk, Reset (async, active-high)
//           MemWrite, DataAddress, WriteData - store port from the core
//           ReadData                         - combinational load data
//           Done, Pass                       - sticky test outcome
//           StoreCount                       - accepted stores, saturating
//           trace_valid/ready/addr/data      - trace FIFO head, valid/ready pop
//           trace_overflow                   - sticky, a trace push was dropped
module dmem_store_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH       = 64,
   parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF,
   parameter logic [31:0] PASS_VALUE  = PASS_VALUE_DEF,
   parameter int          TRACE_DEPTH = 4
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAddress,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Done,
   output logic        Pass,
   output logic [15:0] StoreCount,
   output logic        trace_valid,
   input  logic        trace_ready,
   output logic [31:0] trace_addr,
   output logic [31:0] trace_data,
   output logic        trace_overflow
);

   localparam int          IDX_W     = $clog2(DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

   logic [31:0]      ram [DEPTH];
   dmem_state_t      state;
   dmem_state_t      state_next;
   logic             accept;
   logic             ram_we;
   logic             status_hit;
   logic             in_range;
   logic [IDX_W-1:0] word_idx;
   logic             trace_empty;
   store_rec_t       trace_head;
   store_rec_t       trace_rec;

   assign word_idx   = DataAddress[IDX_W+1:2];
   assign in_range   = (DataAddress < RAM_BYTES);
   assign status_hit = (DataAddress[31:2] == STATUS_ADDR[31:2]);

   assign Done = (state != RUN);
   assign Pass = (state == PASS);

   // Status register shadows whichever RAM word it overlaps.
   always_comb begin
      ReadData = 32'h0;
      if (status_hit) begin
         ReadData = {30'b0, Done & ~Pass, Pass};
      end else if (in_range) begin
         ReadData = ram[word_idx];
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Only RUN accepts stores; PASS and FAIL ignore the bus until reset.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      ram_we     = 1'b0;
      if (state == RUN && MemWrite) begin
         accept = 1'b1;
         if (status_hit) begin
            state_next = (WriteData == PASS_VALUE) ? PASS : FAIL;
         end else if (!in_range) begin
            state_next = FAIL;
         end else begin
            ram_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ram[i] <= '0;
         end
      end else if (ram_we) begin
         ram[word_idx] <= WriteData;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         StoreCount <= '0;
      end else if (accept && StoreCount != 16'hFFFF) begin
         StoreCount <= StoreCount + 16'd1;
      end
   end

   assign trace_rec.addr = DataAddress;
   assign trace_rec.data = WriteData;

   store_trace_fifo #(
      .DEPTH (TRACE_DEPTH)
   ) u_trace (
      .clk      (clk),
      .rst      (Reset),
      .push     (accept),
      .push_rec (trace_rec),
      .pop      (trace_ready),
      .head     (trace_head),
      .empty    (trace_empty),
      .overflow (trace_overflow)
   );

   assign trace_valid = !trace_empty;
   assign trace_addr  = trace_head.addr;
   assign trace_data  = trace_head.data;

endmodule

// File: tb/tb_dmem_store_responder.sv
// tb/tb_dmem_store_responder.sv - directed self-checking bench for dmem_store_responder
module tb_dmem_store_responder;

   logic        clk;
   logic        Reset;
   logic        MemWrite;
   logic [31:0] DataAddress;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Done;
   logic        Pass;
   logic [15:0] StoreCount;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_addr;
   logic [31:0] trace_data;
   logic        trace_overflow;

   int errors;
   int checks;

   dmem_store_responder dut (
      .clk            (clk),
      .Reset          (Reset),
      .MemWrite       (MemWrite),
      .DataAddress    (DataAddress),
      .WriteData      (WriteData),
      .ReadData       (ReadData),
      .Done           (Done),
      .Pass           (Pass),
      .StoreCount     (StoreCount),
      .trace_valid    (trace_valid),
      .trace_ready    (trace_ready),
      .trace_addr     (trace_addr),
      .trace_data     (trace_data),
      .trace_overflow (trace_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic apply_reset();
      Reset       = 1'b1;
      MemWrite    = 1'b0;
      trace_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      Reset = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      MemWrite    = 1'b1;
      DataAddress = a;
      WriteData   = d;
      @(negedge clk);
      MemWrite = 1'b0;
   endtask

   task automatic test_reset();
      Reset       = 1'b1;
      MemWrite    = 1'b0;
      trace_ready = 1'b0;
      DataAddress = 32'd100;
      WriteData   = 32'd0;
      #1;
      checks++;
      if ({Done, Pass, trace_valid, trace_overflow} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {Done, Pass, trace_valid, trace_overflow});
      end
      checks++;
      if (StoreCount !== 16'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", StoreCount);
      end
      checks++;
      if (ReadData !== 32'h0) begin
         errors++;
         $display("FAIL reset_status_read: got %h expected 0", ReadData);
      end
      checks++;
      if ({trace_addr, trace_data} !== 64'h0) begin
         errors++;
         $display("FAIL reset_trace_head: got %h expected 0", {trace_addr, trace_data});
      end
      @(negedge clk);
      @(negedge clk);
      Reset = 1'b0;
   endtask

   task automatic test_basic_store();
      apply_reset();
      @(negedge clk);
      MemWrite    = 1'b1;
      DataAddress = 32'd96;
      WriteData   = 32'd7;
      #1;
      checks++;
      if (trace_valid !== 1'b0) begin
         errors++;
         $display("FAIL no_fall_through: got %b expected 0", trace_valid);
      end
      @(negedge clk);
      MemWrite = 1'b0;
      #1;
      checks++;
      if (ReadData !== 32'd7) begin
         errors++;
         $display("FAIL basic_read96: got %h expected 7", ReadData);
      end
      checks++;
      if (StoreCount !== 16'd1 || Done !== 1'b0) begin
         errors++;
         $display("FAIL basic_count_done: got %0d/%b expected 1/0", StoreCount, Done);
      end
      checks++;
      if (trace_valid !== 1'b1 || trace_addr !== 32'd96 || trace_data !== 32'd7) begin
         errors++;
         $display("FAIL basic_trace: got %b %h %h expected 1 60 7", trace_valid, trace_addr, trace_data);
      end
      trace_ready = 1'b1;
      @(negedge clk);
      trace_ready = 1'b0;
      checks++;
      if (trace_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_pop_empty: got %b expected 0", trace_valid);
      end
   endtask

   task automatic test_pass();
      apply_reset();
      store(32'd96, 32'd7);
      store(32'd100, 32'd25);
      checks++;
      if (Done !== 1'b1 || Pass !== 1'b1) begin
         errors++;
         $display("FAIL pass_flags: got %b%b expected 11", Done, Pass);
      end
      DataAddress = 32'd100;
      #1;
      checks++;
      if (ReadData !== 32'h1) begin
         errors++;
         $display("FAIL pass_status_read: got %h expected 1", ReadData);
      end
      store(32'd96, 32'd99);
      DataAddress = 32'd96;
      #1;
      checks++;
      if (ReadData !== 32'd7) begin
         errors++;
         $display("FAIL pass_ignored_ram: got %h expected 7", ReadData);
      end
      checks++;
      if (StoreCount !== 16'd2) begin
         errors++;
         $display("FAIL pass_ignored_count: got %0d expected 2", StoreCount);
      end
      checks++;
      if (trace_valid !== 1'b1 || trace_addr !== 32'd96 || trace_data !== 32'd7) begin
         errors++;
         $display("FAIL pass_trace0: got %b %h %h expected 1 60 7", trace_valid, trace_addr, trace_data);
      end
      trace_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (trace_valid !== 1'b1 || trace_addr !== 32'd100 || trace_data !== 32'd25) begin
         errors++;
         $display("FAIL pass_trace1: got %b %h %h expected 1 64 19", trace_valid, trace_addr, trace_data);
      end
      @(negedge clk);
      trace_ready = 1'b0;
      checks++;
      if (trace_valid !== 1'b0) begin
         errors++;
         $display("FAIL pass_trace_only_two: got %b expected 0", trace_valid);
      end
   endtask

   task automatic test_fail();
      apply_reset();
      store(32'd100, 32'd24);
      DataAddress = 32'd100;
      #1;
      checks++;
      if (Done !== 1'b1 || Pass !== 1'b0 || ReadData !== 32'h2) begin
         errors++;
         $display("FAIL fail_status: got %b%b %h expected 10 2", Done, Pass, ReadData);
      end
      apply_reset();
      store(32'd252, 32'h0000ABCD);
      DataAddress = 32'd252;
      #1;
      checks++;
      if (ReadData !== 32'h0000ABCD || Done !== 1'b0) begin
         errors++;
         $display("FAIL last_word: got %h %b expected abcd 0", ReadData, Done);
      end
      store(32'd256, 32'd5);
      DataAddress = 32'd256;
      #1;
      checks++;
      if (Done !== 1'b1 || Pass !== 1'b0 || ReadData !== 32'h0) begin
         errors++;
         $display("FAIL oor_fail: got %b%b %h expected 10 0", Done, Pass, ReadData);
      end
      checks++;
      if (StoreCount !== 16'd2) begin
         errors++;
         $display("FAIL oor_count: got %0d expected 2", StoreCount);
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         store(32'(4 * i), 32'(16 + i));
      end
      checks++;
      if (trace_overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_not_yet: got %b expected 0", trace_overflow);
      end
      store(32'd16, 32'd20);
      checks++;
      if (trace_overflow !== 1'b1 || StoreCount !== 16'd5) begin
         errors++;
         $display("FAIL ovf_set: got %b %0d expected 1 5", trace_overflow, StoreCount);
      end
      trace_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (trace_valid !== 1'b1 || trace_addr !== 32'(4 * i) || trace_data !== 32'(16 + i)) begin
            errors++;
            $display("FAIL ovf_drain%0d: got %b %h %h expected 1 %h %h",
                     i, trace_valid, trace_addr, trace_data, 32'(4 * i), 32'(16 + i));
         end
         @(negedge clk);
      end
      trace_ready = 1'b0;
      checks++;
      if (trace_valid !== 1'b0 || trace_overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_after_drain: got %b %b expected 0 1", trace_valid, trace_overflow);
      end
   endtask

   task automatic test_full_push_pop();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         store(32'(4 * i), 32'(32 + i));
      end
      @(negedge clk);
      MemWrite    = 1'b1;
      DataAddress = 32'd16;
      WriteData   = 32'd36;
      trace_ready = 1'b1;
      @(negedge clk);
      MemWrite    = 1'b0;
      trace_ready = 1'b0;
      checks++;
      if (trace_overflow !== 1'b0 || StoreCount !== 16'd5) begin
         errors++;
         $display("FAIL fpp_no_ovf: got %b %0d expected 0 5", trace_overflow, StoreCount);
      end
      trace_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (trace_valid !== 1'b1 || trace_addr !== 32'(4 * i) || trace_data !== 32'(32 + i)) begin
            errors++;
            $display("FAIL fpp_drain%0d: got %b %h %h expected 1 %h %h",
                     i, trace_valid, trace_addr, trace_data, 32'(4 * i), 32'(32 + i));
         end
         @(negedge clk);
      end
      trace_ready = 1'b0;
      checks++;
      if (trace_valid !== 1'b0) begin
         errors++;
         $display("FAIL fpp_count4: got %b expected 0", trace_valid);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      store(32'd0, 32'h11);
      store(32'd4, 32'h22);
      store(32'd8, 32'h33);
      store(32'd100, 32'd25);
      DataAddress = 32'd4;
      #1;
      checks++;
      if (ReadData !== 32'h22 || Done !== 1'b1) begin
         errors++;
         $display("FAIL ares_before: got %h %b expected 22 1", ReadData, Done);
      end
      #1;
      Reset = 1'b1;
      #1;
      checks++;
      if ({Done, Pass, trace_valid, trace_overflow} !== 4'b0000 || StoreCount !== 16'd0) begin
         errors++;
         $display("FAIL ares_flags: got %b %0d expected 0000 0", {Done, Pass, trace_valid, trace_overflow}, StoreCount);
      end
      checks++;
      if (ReadData !== 32'h0 || {trace_addr, trace_data} !== 64'h0) begin
         errors++;
         $display("FAIL ares_data: got %h %h expected 0 0", ReadData, {trace_addr, trace_data});
      end
      @(negedge clk);
      Reset = 1'b0;
      DataAddress = 32'd8;
      #1;
      checks++;
      if (ReadData !== 32'h0) begin
         errors++;
         $display("FAIL ares_ram_cleared: got %h expected 0", ReadData);
      end
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      Reset       = 1'b1;
      MemWrite    = 1'b0;
      DataAddress = 32'd0;
      WriteData   = 32'd0;
      trace_ready = 1'b0;
      test_reset();
      test_basic_store();
      test_pass();
      test_fail();
      test_overflow();
      test_full_push_pop();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
